calc_unit_scheduler: RTL and testbench

Sequencer and arbiter for the calculator's four multi-cycle operator units (square root, power, factorial, division). Two requesters, for example the keypad number-former and a chained-operation path, submit an opcode and two 28-bit operands. The block arbitrates round-robin, issues a one-cycle start to the selected unit, and waits for that unit's done. It then returns the result and an error code to the winning requester. It sits between the operand/state logic and the operator units, replacing ad-hoc select-bit driving of their `valid_in` inputs.

---
 rtl/calc_sched_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 15 +
 rtl/calc_unit_scheduler.sv | 150 +++++++++++++++
 tb/tb_calc_unit_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_sched_pkg.sv
// calc_sched_pkg: opcodes, error codes and FSM encoding shared by the
// calculator operator-unit scheduler.
package calc_sched_pkg;

    localparam logic [1:0] OP_SQRT = 2'd0;
    localparam logic [1:0] OP_POW  = 2'd1;
    localparam logic [1:0] OP_FACT = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_UNIT    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] oh;
        oh = 4'b0000;
        case (op)
            OP_SQRT: oh = 4'b0001;
            OP_POW:  oh = 4'b0010;
            OP_FACT: oh = 4'b0100;
            OP_DIV:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; on contention the requester
// that was not served last wins.
module rr_arb2 (
    input  logic en,
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = en && req0 && (!req1 || last);
    assign gnt1 = en && req1 && (!req0 || !last);

endmodule

// File: rtl/calc_unit_scheduler.sv
// calc_unit_scheduler: round-robin sequencer for the sqrt/power/factorial/divide
// units. Define CALC_SCHED_TIMEOUT_EN to build the WAIT-state watchdog.
//
// state | meaning
// IDLE  | arbitrate; capture winner's owner, opcode and operands on grant
// ISSUE | one-cycle start pulse to the selected unit, watchdog reload
// WAIT  | wait for the selected unit's done (or watchdog expiry)
// DONE  | done pulse to the owner, last-served pointer update
module calc_unit_scheduler #(
    parameter int DW      = 28,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [1:0]      op0,
    input  logic [1:0]      op1,
    input  logic [DW-1:0]   a0,
    input  logic [DW-1:0]   b0,
    input  logic [DW-1:0]   a1,
    input  logic [DW-1:0]   b1,
    output logic            gnt0,
    output logic            gnt1,
    input  logic            abort,
    output logic [3:0]      unit_start,
    output logic [DW-1:0]   unit_n1,
    output logic [DW-1:0]   unit_n2,
    input  logic [3:0]      unit_done,
    input  logic [3:0]      unit_err,
    input  logic [4*DW-1:0] unit_res,
    output logic            done0,
    output logic            done1,
    output logic [DW-1:0]   result,
    output logic [1:0]      err_code,
    output logic            busy
);
    import calc_sched_pkg::*;

    sched_state_t state, state_nxt;
    logic         owner_q;
    logic         last_q;
    logic [1:0]   op_q;
    logic         arb_en;
    logic         grant;
    logic         unit_hit;
    logic         wd_expired;

    assign arb_en = (state == ST_IDLE) && !abort;

    rr_arb2 u_arb (
        .en   (arb_en),
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign grant    = gnt0 || gnt1;
    assign unit_hit = (state == ST_WAIT) && unit_done[op_q];
    assign busy     = (state != ST_IDLE);

`ifdef CALC_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    // Down-counter reloaded in ISSUE; holds at zero so it can never wrap.
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= WD_W'(TIMEOUT);
        end else if ((state == ST_WAIT) && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    assign wd_expired = (state == ST_WAIT) && (wd_cnt == '0);
`else
    // Without the watchdog TIMEOUT has no effect.
    localparam int TIMEOUT_UNUSED = TIMEOUT;
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        unit_start = 4'b0000;
        done0      = 1'b0;
        done1      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                unit_start = op_onehot(op_q);
                state_nxt  = abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort)                       state_nxt = ST_IDLE;
                else if (unit_hit || wd_expired) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                done0     = !abort && !owner_q;
                done1     = !abort &&  owner_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= OP_SQRT;
            unit_n1  <= '0;
            unit_n2  <= '0;
            result   <= '0;
            err_code <= ERR_OK;
        end else begin
            if (grant) begin
                owner_q <= gnt1;
                op_q    <= gnt1 ? op1 : op0;
                unit_n1 <= gnt1 ? a1 : a0;
                unit_n2 <= gnt1 ? b1 : b0;
            end
            // abort outranks both a unit completion and a watchdog expiry
            if (!abort && unit_hit) begin
                result   <= unit_res[op_q*DW +: DW];
                err_code <= unit_err[op_q] ? ERR_UNIT : ERR_OK;
            end else if (!abort && wd_expired) begin
                err_code <= ERR_TIMEOUT;
            end
            if ((state == ST_DONE) && !abort) begin
                last_q <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_calc_unit_scheduler.sv
// Directed and randomized checks of calc_unit_scheduler against a
// transaction-level model of arbitration and operator results.
module tb_calc_unit_scheduler;

    localparam int DW = 28;
    localparam int TO = 16;

    logic            clk;
    logic            rst;
    logic            req0, req1;
    logic [1:0]      op0, op1;
    logic [DW-1:0]   a0, b0, a1, b1;
    logic            gnt0, gnt1;
    logic            abort;
    logic [3:0]      unit_start;
    logic [DW-1:0]   unit_n1, unit_n2;
    logic [3:0]      unit_done;
    logic [3:0]      unit_err;
    logic [4*DW-1:0] unit_res;
    logic            done0, done1;
    logic [DW-1:0]   result;
    logic [1:0]      err_code;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // model state
    bit            last_served = 1'b1;
    logic [DW-1:0] last_result = '0;
    logic [1:0]    last_err    = 2'd0;

    calc_unit_scheduler #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .abort      (abort),
        .unit_start (unit_start),
        .unit_n1    (unit_n1),
        .unit_n2    (unit_n2),
        .unit_done  (unit_done),
        .unit_err   (unit_err),
        .unit_res   (unit_res),
        .done0      (done0),
        .done1      (done1),
        .result     (result),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] calc(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (64'd1 << DW) - 64'd1;
        r    = 64'd0;
        case (op)
            2'd0: while ((r + 64'd1) * (r + 64'd1) <= 64'(a)) r = r + 64'd1;
            2'd1: begin
                r = 64'd1;
                for (int i = 0; i < int'(b); i++) r = (r * 64'(a)) & mask;
            end
            2'd2: begin
                r = 64'd1;
                for (int i = 2; i <= int'(a); i++) r = r * 64'(i);
            end
            default: r = 64'(a / b);
        endcase
        return r[DW-1:0];
    endfunction

    task automatic rand_unit_res();
        for (int k = 0; k < 4; k++) unit_res[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic rand_operands(input logic [1:0] op, output logic [DW-1:0] a,
                                 output logic [DW-1:0] b);
        case (op)
            2'd0: begin a = DW'($urandom_range(0, 1000000)); b = DW'($urandom); end
            2'd1: begin a = DW'($urandom_range(0, 12));      b = DW'($urandom_range(0, 6)); end
            2'd2: begin a = DW'($urandom_range(0, 11));      b = DW'($urandom); end
            default: begin a = DW'($urandom);                b = DW'($urandom_range(1, 5000)); end
        endcase
    endtask

    // One complete transaction from an IDLE window through the DONE window.
    task automatic transact(input bit r0, input bit r1, input logic [1:0] o0, input logic [1:0] o1,
                            input logic [DW-1:0] x0, input logic [DW-1:0] y0,
                            input logic [DW-1:0] x1, input logic [DW-1:0] y1,
                            input int lat, input bit uerr);
        int            w;
        logic [1:0]    wop;
        logic [DW-1:0] wa, wb, exp_res;
        logic [3:0]    oh, noise, ue;
        w   = (r0 && r1) ? (last_served ? 0 : 1) : (r0 ? 0 : 1);
        wop = (w == 0) ? o0 : o1;
        wa  = (w == 0) ? x0 : x1;
        wb  = (w == 0) ? y0 : y1;
        oh  = 4'b0001 << wop;
        exp_res = calc(wop, wa, wb);
        req0 = r0; req1 = r1; op0 = o0; op1 = o1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant0", gnt0, w == 0);
        chk("grant1", gnt1, w == 1);
        tick();
        if (w == 0) req0 = 1'b0; else req1 = 1'b0;
        #1;
        chk("issue_start", unit_start, oh);
        chk("issue_n1", unit_n1, wa);
        chk("issue_n2", unit_n2, wb);
        chk("issue_nogrant", {gnt0, gnt1}, 0);
        chk("issue_busy", busy, 1);
        tick();
        for (int i = 1; i < lat; i++) begin
            noise = 4'($urandom);
            noise[wop] = 1'b0;
            unit_done = noise;
            rand_unit_res();
            #1;
            chk("wait_nodone", {done0, done1}, 0);
            chk("wait_nostart", unit_start, 0);
            tick();
        end
        noise = 4'($urandom);
        noise[wop] = 1'b1;
        unit_done = noise;
        ue = 4'($urandom);
        ue[wop] = uerr;
        unit_err = ue;
        rand_unit_res();
        unit_res[int'(wop)*DW +: DW] = exp_res;
        #1;
        chk("hit_nodone", {done0, done1}, 0);
        tick();
        unit_done = 4'b0000;
        unit_err  = 4'b0000;
        #1;
        chk("done0", done0, w == 0);
        chk("done1", done1, w == 1);
        chk("result", result, exp_res);
        chk("err_code", err_code, uerr ? 2'd1 : 2'd0);
        chk("done_nogrant", {gnt0, gnt1}, 0);
        last_served = (w == 1);
        last_result = exp_res;
        last_err    = uerr ? 2'd1 : 2'd0;
        tick();
    endtask

    initial begin
        bit            r0, r1;
        logic [1:0]    o0, o1;
        logic [DW-1:0] x0, y0, x1, y1;
        int            n;

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = 2'd0; op1 = 2'd0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; abort = 1'b0;
        unit_done = 4'b0000; unit_err = 4'b0000; unit_res = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_grant", {gnt0, gnt1}, 0);
        chk("rst_start", unit_start, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_n1", unit_n1, 0);
        chk("rst_n2", unit_n2, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err_code, 0);
        tick();
        rst = 1'b1;
        tick();

        // both requesters from reset: 100/7 on 0 and sqrt 81 on 1
        transact(1, 1, 2'd3, 2'd0, 28'd100, 28'd7, 28'd81, 28'd0, 3, 0);
        // requester 0 re-requests while 1 is still pending: 1 goes first
        transact(1, 1, 2'd3, 2'd0, 28'd100, 28'd7, 28'd81, 28'd0, 2, 0);
        transact(1, 1, 2'd3, 2'd0, 28'd100, 28'd7, 28'd81, 28'd0, 1, 0);
        // factorial 5 with a 4-cycle unit
        transact(1, 0, 2'd2, 2'd0, 28'd5, 28'd0, 28'd0, 28'd0, 4, 0);
        // power 10^9 overflowing, unit flags error
        transact(0, 1, 2'd0, 2'd1, 28'd0, 28'd0, 28'd10, 28'd9, 5, 1);

        for (int it = 0; it < 24; it++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            o0 = 2'($urandom);
            o1 = 2'($urandom);
            rand_operands(o0, x0, y0);
            rand_operands(o1, x1, y1);
            transact(r0, r1, o0, o1, x0, y0, x1, y1, $urandom_range(1, 6), ($urandom_range(0, 3) == 0));
        end

        // abort in the third WAIT cycle of a factorial
        req0 = 1'b1; req1 = 1'b0; op0 = 2'd2; a0 = 28'd5; b0 = 28'd0;
        #1;
        chk("ab_grant0", gnt0, 1);
        tick();
        req0 = 1'b0;
        #1;
        chk("ab_start", unit_start, 4'b0100);
        tick();
        tick();
        tick();
        abort = 1'b1;
        #1;
        chk("ab_wait_busy", busy, 1);
        tick();
        req1 = 1'b1; op1 = 2'd0; a1 = 28'd49; b1 = 28'd0;
        #1;
        chk("ab_idle_busy", busy, 0);
        chk("ab_idle_nogrant", gnt1, 0);
        chk("ab_idle_nodone", {done0, done1}, 0);
        tick();
        unit_done = 4'b0100;
        unit_res[2*DW +: DW] = 28'd120;
        #1;
        chk("ab_late_nogrant", gnt1, 0);
        chk("ab_late_nodone", {done0, done1}, 0);
        tick();
        unit_done = 4'b0000;
        abort = 1'b0;
        #1;
        chk("ab_result_held", result, last_result);
        chk("ab_err_held", err_code, last_err);
        chk("ab_after_nodone", {done0, done1}, 0);
        transact(0, 1, 2'd0, 2'd0, 28'd0, 28'd0, 28'd49, 28'd0, 2, 0);

`ifdef CALC_SCHED_TIMEOUT_EN
        // unit never answers: watchdog finishes the operation
        req0 = 1'b1; req1 = 1'b0; op0 = 2'd3; a0 = 28'd50; b0 = 28'd5;
        #1;
        chk("to_grant0", gnt0, 1);
        tick();
        req0 = 1'b0;
        #1;
        chk("to_start", unit_start, 4'b1000);
        n = 0;
        while (!done0 && n < 200) begin
            tick();
            #1;
            n++;
        end
        chk("to_latency", n, TO + 2);
        chk("to_err", err_code, 2);
        chk("to_result_held", result, last_result);
        last_served = 1'b0;
        last_err    = 2'd2;
        tick();
`endif

        // leave the pointer on requester 0, then reset during WAIT
        transact(1, 0, 2'd1, 2'd0, 28'd2, 28'd3, 28'd0, 28'd0, 2, 0);
        req0 = 1'b1; op0 = 2'd1; a0 = 28'd3; b0 = 28'd4;
        #1;
        chk("rw_grant0", gnt0, 1);
        tick();
        req0 = 1'b0;
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_start", unit_start, 0);
        chk("rw_done", {done0, done1}, 0);
        chk("rw_n1", unit_n1, 0);
        chk("rw_n2", unit_n2, 0);
        chk("rw_result", result, 0);
        chk("rw_err", err_code, 0);
        last_served = 1'b1;
        last_result = '0;
        last_err    = 2'd0;
        tick();
        rst = 1'b1;
        tick();
        transact(1, 1, 2'd2, 2'd3, 28'd6, 28'd0, 28'd1000, 28'd9, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
